// File: rtl/usbfs_serial_reg_bridge.sv
// Turns host-to-device bytes into register read/write strobes and returns the read data
// on the device-to-host byte stream. A byte with bit 7 set is a write, and the next byte is its data.
module usbfs_serial_reg_bridge #(
  parameter int ADDR_W    = 7,
  parameter int TIMEOUT   = 48000,
  parameter int TIMEOUT_W = $clog2(TIMEOUT + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_rx_ready,
  output logic              o_tx_valid,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_ready,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic              o_reg_wrEn,
  output logic [7:0]        o_reg_wrData,
  output logic              o_reg_rdEn,
  input  logic [7:0]        i_reg_rdData,
  output logic              o_timeout
);

  // A zero TIMEOUT gives a zero-width counter, so the counter is kept at least one bit wide.
  localparam int CNT_W = (TIMEOUT_W < 1) ? 1 : TIMEOUT_W;
  localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic TIMEOUT_EN = (TIMEOUT > 0);

  typedef enum logic [2:0] {
    IDLE,
    WRDATA,
    RDEN,
    RDCAP,
    RESP
  } stateT;

  stateT            state;
  logic [CNT_W-1:0] timeoutCnt;
  logic             rxAccept;
  logic             unusedRxBits;

  assign rxAccept     = i_rx_valid && o_rx_ready;
  assign unusedRxBits = ^(i_rx_data >> ADDR_W);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      timeoutCnt   <= '0;
      o_rx_ready   <= 1'b1;
      o_tx_valid   <= 1'b0;
      o_tx_data    <= 8'h00;
      o_reg_addr   <= '0;
      o_reg_wrEn   <= 1'b0;
      o_reg_wrData <= 8'h00;
      o_reg_rdEn   <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      o_reg_wrEn <= 1'b0;
      o_reg_rdEn <= 1'b0;
      o_timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (rxAccept) begin
            o_reg_addr <= i_rx_data[ADDR_W-1:0];
            if (i_rx_data[7]) begin
              timeoutCnt <= '0;
              state      <= WRDATA;
            end else begin
              o_reg_rdEn <= 1'b1;
              o_rx_ready <= 1'b0;
              state      <= RDEN;
            end
          end
        end
        WRDATA: begin
          // A data byte arriving on the terminal-count cycle still completes the write.
          if (rxAccept) begin
            o_reg_wrEn   <= 1'b1;
            o_reg_wrData <= i_rx_data;
            state        <= IDLE;
          end else if (TIMEOUT_EN && (timeoutCnt == TIMEOUT_TC)) begin
            o_timeout <= 1'b1;
            state     <= IDLE;
          end else begin
            timeoutCnt <= timeoutCnt + 1'b1;
          end
        end
        RDEN: begin
          state <= RDCAP;
        end
        RDCAP: begin
          o_tx_data  <= i_reg_rdData;
          o_tx_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (i_tx_ready) begin
            o_tx_valid <= 1'b0;
            o_rx_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          o_tx_valid <= 1'b0;
          o_rx_ready <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usbfs_serial_reg_bridge.sv
// Directed bench: instance A uses ADDR_W=7 and TIMEOUT=16, and instance B uses ADDR_W=4 with the timeout disabled.
// Both instances share the same inputs, and each expected value was worked out by hand.
module tb_usbfs_serial_reg_bridge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxValid = 1'b0;
  logic [7:0] rxData = 8'h00;
  logic       txReady = 1'b1;
  logic [7:0] rdData = 8'hEE;
  logic [7:0] rdValue = 8'h00;

  logic       aRxReady, aTxValid, aWrEn, aRdEn, aTimeout;
  logic [7:0] aTxData, aWrData;
  logic [6:0] aAddr;
  logic       bRxReady, bTxValid, bWrEn, bRdEn, bTimeout;
  logic [7:0] bTxData, bWrData;
  logic [3:0] bAddr;

  int total = 0;
  int bad = 0;
  int wrCnt = 0, rdCnt = 0, toCnt = 0, xferCnt = 0;
  int wrSnap, rdSnap, toSnap, xferSnap;

  always #5 clk = ~clk;

  usbfs_serial_reg_bridge #(.ADDR_W(7), .TIMEOUT(16)) dutA (
    .i_clk(clk), .i_rst(rst), .i_rx_valid(rxValid), .i_rx_data(rxData),
    .o_rx_ready(aRxReady), .o_tx_valid(aTxValid), .o_tx_data(aTxData),
    .i_tx_ready(txReady), .o_reg_addr(aAddr), .o_reg_wrEn(aWrEn),
    .o_reg_wrData(aWrData), .o_reg_rdEn(aRdEn), .i_reg_rdData(rdData),
    .o_timeout(aTimeout)
  );

  usbfs_serial_reg_bridge #(.ADDR_W(4), .TIMEOUT(0)) dutB (
    .i_clk(clk), .i_rst(rst), .i_rx_valid(rxValid), .i_rx_data(rxData),
    .o_rx_ready(bRxReady), .o_tx_valid(bTxValid), .o_tx_data(bTxData),
    .i_tx_ready(txReady), .o_reg_addr(bAddr), .o_reg_wrEn(bWrEn),
    .o_reg_wrData(bWrData), .o_reg_rdEn(bRdEn), .i_reg_rdData(rdData),
    .o_timeout(bTimeout)
  );

  // The register file model presents data only in the cycle after a read strobe from instance A.
  always @(posedge clk) begin
    rdData <= aRdEn ? rdValue : 8'hEE;
    if (aWrEn) wrCnt <= wrCnt + 1;
    if (aRdEn) rdCnt <= rdCnt + 1;
    if (aTimeout) toCnt <= toCnt + 1;
    if (aTxValid && txReady) xferCnt <= xferCnt + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    // reset values
    cyc();
    cyc();
    chk("rst_rxReady", 32'(aRxReady), 1);
    chk("rst_txValid", 32'(aTxValid), 0);
    chk("rst_txData", 32'(aTxData), 0);
    chk("rst_addr", 32'(aAddr), 0);
    chk("rst_wrEn", 32'(aWrEn), 0);
    chk("rst_wrData", 32'(aWrData), 0);
    chk("rst_rdEn", 32'(aRdEn), 0);
    chk("rst_timeout", 32'(aTimeout), 0);
    rst = 1'b0;
    cyc();

    // write 0x85, 0xA5 with valid held high
    rxValid = 1'b1; rxData = 8'h85;
    cyc();
    chk("wr_cmd_rxReady", 32'(aRxReady), 1);
    chk("wr_cmd_wrEn", 32'(aWrEn), 0);
    chk("wr_cmd_addr", 32'(aAddr), 32'h05);
    rxData = 8'hA5;
    cyc();
    chk("wr_wrEn", 32'(aWrEn), 1);
    chk("wr_addr", 32'(aAddr), 32'h05);
    chk("wr_wrData", 32'(aWrData), 32'hA5);
    chk("wr_rdEn", 32'(aRdEn), 0);
    rxValid = 1'b0;
    cyc();
    chk("wr_wrEn_once", 32'(aWrEn), 0);
    chk("wr_txValid", 32'(aTxValid), 0);
    chk("wr_cnt", 32'(wrCnt), 1);

    // read 0x05 returning 0x3C, tx ready
    rdValue = 8'h3C; txReady = 1'b1;
    rxValid = 1'b1; rxData = 8'h05;
    cyc();
    chk("rd_n1_rdEn", 32'(aRdEn), 1);
    chk("rd_n1_rxReady", 32'(aRxReady), 0);
    chk("rd_n1_addr", 32'(aAddr), 32'h05);
    chk("rd_n1_txValid", 32'(aTxValid), 0);
    rxValid = 1'b0;
    cyc();
    chk("rd_n2_rdEn", 32'(aRdEn), 0);
    chk("rd_n2_rxReady", 32'(aRxReady), 0);
    chk("rd_n2_txValid", 32'(aTxValid), 0);
    cyc();
    chk("rd_n3_txValid", 32'(aTxValid), 1);
    chk("rd_n3_txData", 32'(aTxData), 32'h3C);
    chk("rd_n3_rxReady", 32'(aRxReady), 0);
    cyc();
    chk("rd_n4_txValid", 32'(aTxValid), 0);
    chk("rd_n4_rxReady", 32'(aRxReady), 1);
    chk("rd_rdCnt", 32'(rdCnt), 1);
    chk("rd_xferCnt", 32'(xferCnt), 1);

    // new command accepted in the write strobe cycle
    rdValue = 8'h5A;
    rxValid = 1'b1; rxData = 8'h83;
    cyc();
    rxData = 8'h44;
    cyc();
    chk("b2b_wrEn", 32'(aWrEn), 1);
    chk("b2b_wrData", 32'(aWrData), 32'h44);
    chk("b2b_wrAddr", 32'(aAddr), 32'h03);
    chk("b2b_rxReady", 32'(aRxReady), 1);
    rxData = 8'h02;
    cyc();
    chk("b2b_rdEn", 32'(aRdEn), 1);
    chk("b2b_wrEn_off", 32'(aWrEn), 0);
    chk("b2b_rdAddr", 32'(aAddr), 32'h02);
    rxValid = 1'b0;
    cyc();
    cyc();
    chk("b2b_txValid", 32'(aTxValid), 1);
    chk("b2b_txData", 32'(aTxData), 32'h5A);
    cyc();
    chk("b2b_done", 32'(aTxValid), 0);

    // read with the response stalled for 10 cycles
    rdValue = 8'h96; txReady = 1'b0;
    rxValid = 1'b1; rxData = 8'h06;
    cyc();
    rxData = 8'h81;
    cyc();
    cyc();
    chk("stall_txValid", 32'(aTxValid), 1);
    chk("stall_txData", 32'(aTxData), 32'h96);
    xferSnap = xferCnt;
    wrSnap = wrCnt;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("stall_hold_valid", 32'(aTxValid), 1);
      chk("stall_hold_data", 32'(aTxData), 32'h96);
      chk("stall_rxReady", 32'(aRxReady), 0);
    end
    txReady = 1'b1; rxValid = 1'b0;
    cyc();
    chk("stall_released", 32'(aTxValid), 0);
    chk("stall_rxReady_back", 32'(aRxReady), 1);
    cyc();
    chk("stall_one_xfer", 32'(xferCnt - xferSnap), 1);
    chk("stall_no_wr", 32'(wrCnt - wrSnap), 0);

    // timeout: 0x82 then idle; the pulse appears 16 edges after the accept
    wrSnap = wrCnt; toSnap = toCnt;
    rxValid = 1'b1; rxData = 8'h82;
    cyc();
    rxValid = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      cyc();
      chk("to_early", 32'(aTimeout), 0);
    end
    cyc();
    chk("to_pulse", 32'(aTimeout), 1);
    chk("to_rxReady", 32'(aRxReady), 1);
    chk("to_disabled_B", 32'(bTimeout), 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("to_after", 32'(aTimeout), 0);
    end
    chk("to_count", 32'(toCnt - toSnap), 1);
    chk("to_no_wr", 32'(wrCnt - wrSnap), 0);
    rdValue = 8'h11;
    rxValid = 1'b1; rxData = 8'h01;
    cyc();
    chk("to_next_rdEn", 32'(aRdEn), 1);
    chk("to_next_addr", 32'(aAddr), 32'h01);
    chk("to_B_still_wr", 32'(bWrEn), 1);
    chk("to_B_wrData", 32'(bWrData), 32'h01);
    chk("to_B_addr", 32'(bAddr), 32'h2);
    rxValid = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("to_read_done", 32'(aRxReady), 1);

    // a data byte accepted on the terminal-count cycle wins over the timeout
    wrSnap = wrCnt; toSnap = toCnt;
    rxValid = 1'b1; rxData = 8'h81;
    cyc();
    rxValid = 1'b0;
    for (int k = 1; k <= 15; k++) cyc();
    rxValid = 1'b1; rxData = 8'h77;
    cyc();
    chk("edge_wrEn", 32'(aWrEn), 1);
    chk("edge_wrData", 32'(aWrData), 32'h77);
    chk("edge_timeout", 32'(aTimeout), 0);
    rxValid = 1'b0;
    cyc();
    chk("edge_timeout_after", 32'(toCnt - toSnap), 0);
    chk("edge_wr_count", 32'(wrCnt - wrSnap), 1);

    // narrow address on instance B: write 0xF7, 0x11
    rxValid = 1'b1; rxData = 8'hF7;
    cyc();
    rxData = 8'h11;
    cyc();
    chk("aw4_wrEn", 32'(bWrEn), 1);
    chk("aw4_addr", 32'(bAddr), 32'h7);
    chk("aw4_wrData", 32'(bWrData), 32'h11);
    chk("aw7_addr", 32'(aAddr), 32'h77);
    rxValid = 1'b0;
    cyc();

    // reset while in RESP
    rdValue = 8'hC3; txReady = 1'b0;
    rxValid = 1'b1; rxData = 8'h03;
    cyc();
    rxValid = 1'b0;
    cyc();
    cyc();
    chk("rstresp_pre_valid", 32'(aTxValid), 1);
    rst = 1'b1;
    cyc();
    chk("rstresp_txValid", 32'(aTxValid), 0);
    chk("rstresp_txData", 32'(aTxData), 0);
    chk("rstresp_rxReady", 32'(aRxReady), 1);
    chk("rstresp_addr", 32'(aAddr), 0);
    rst = 1'b0; txReady = 1'b1;
    wrSnap = wrCnt; rdSnap = rdCnt; xferSnap = xferCnt;
    for (int k = 0; k < 4; k++) cyc();
    chk("rstresp_no_rd", 32'(rdCnt - rdSnap), 0);
    chk("rstresp_no_xfer", 32'(xferCnt - xferSnap), 0);

    // reset while in WRDATA, with a data byte arriving alongside the reset
    toSnap = toCnt;
    rxValid = 1'b1; rxData = 8'h84;
    cyc();
    rst = 1'b1; rxData = 8'h99;
    cyc();
    chk("rstwr_wrEn", 32'(aWrEn), 0);
    chk("rstwr_wrData", 32'(aWrData), 0);
    chk("rstwr_rxReady", 32'(aRxReady), 1);
    rst = 1'b0; rxValid = 1'b0;
    for (int k = 0; k < 20; k++) cyc();
    chk("rstwr_no_wr", 32'(wrCnt - wrSnap), 0);
    chk("rstwr_no_rd", 32'(rdCnt - rdSnap), 0);
    chk("rstwr_no_timeout", 32'(toCnt - toSnap), 0);

    // after the reset, a read command is accepted as soon as it arrives
    rxValid = 1'b1; rxData = 8'h09;
    cyc();
    chk("post_rst_rdEn", 32'(aRdEn), 1);
    chk("post_rst_addr", 32'(aAddr), 32'h09);
    rxValid = 1'b0;
    for (int k = 0; k < 4; k++) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
